// File: rtl/f_fetch_unit.sv
// f_fetch_unit: F-stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches words from a variable-latency instruction memory,
// presents F_PC/F_inStr/F_valid to the IF/ID register, inserts NOP bubbles
// while a fetch is outstanding and applies D-stage redirects after the
// delay slot.
// Optional feature: define F_FETCH_PERF_EN to add the perf_bubbles and
// perf_hold saturating counters.
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_STALL,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_inStr,
  output logic        F_valid
`ifdef F_FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_hold
`endif
);

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        consume;
  logic        capture;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign imem_addr = F_PC;

  // State, PC, hold buffer and pending-redirect registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      buf_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Output decode, next-state and next-PC selection
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    imem_req  = 1'b0;
    F_PC      = pc_q;
    F_inStr   = '0;
    F_valid   = 1'b0;
    consume   = 1'b0;
    capture   = 1'b0;
    next_pc   = pc_q + 32'(PC_STEP);

    if (!reset) begin
      F_PC = RESET_PC;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            F_inStr = imem_rdata;
            F_valid = 1'b1;
            if (F_STALL) begin
              buf_d   = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          F_inStr = buf_q;
          F_valid = 1'b1;
          if (!F_STALL) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      consume = F_valid && !F_STALL;
      capture = redirect_valid && !F_STALL;

      if (pend_v_q) begin
        next_pc = pend_pc_q;
      end else if (redirect_valid) begin
        next_pc = redir_tgt;
      end

      // A target captured at a consume edge is only kept pending when an
      // older pending target is the one being taken now; otherwise the
      // new target has already been applied through next_pc.
      if (consume) begin
        pc_d     = next_pc;
        pend_v_d = 1'b0;
        if (capture && pend_v_q) begin
          pend_v_d  = 1'b1;
          pend_pc_d = redir_tgt;
        end
      end else if (capture) begin
        pend_v_d  = 1'b1;
        pend_pc_d = redir_tgt;
      end
    end
  end

`ifdef F_FETCH_PERF_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_hold_q;

  // Saturating counters of bubble cycles and HOLD cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_bubbles_q <= '0;
      perf_hold_q    <= '0;
    end else begin
      if (!F_valid && (perf_bubbles_q != '1)) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
      if ((state_q == S_HOLD) && (perf_hold_q != '1)) begin
        perf_hold_q <= perf_hold_q + 32'd1;
      end
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_hold    = perf_hold_q;
`endif

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: behavioural fetch-stream model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_f_fetch_unit;

  logic        clk;
  logic        reset;
  logic        F_STALL;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_inStr;
  logic        F_valid;

  f_fetch_unit #(
    .RESET_PC(32'h0000_3000),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .F_STALL       (F_STALL),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .F_PC          (F_PC),
    .F_inStr       (F_inStr),
    .F_valid       (F_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  logic run = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Instruction memory: ready after 'lat' waiting cycles; word = address,
  // except an optional special word at 0x3004. 'stale' forces ready.
  int unsigned lat   = 0;
  int unsigned wcnt  = 0;
  logic        stale = 1'b0;
  logic        spec_word = 1'b0;
  int unsigned n300c = 0;

  assign imem_ready = stale | (imem_req & (wcnt >= lat));
  assign imem_rdata = (spec_word && imem_addr == 32'h3004) ? 32'h2408_0001 : imem_addr;

  always @(posedge clk) begin
    if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    if (imem_req && imem_addr == 32'h300C) n300c <= n300c + 1;
  end

  // Behavioural model: address of the word being delivered, whether a
  // word is being held for a stalled D, and the redirect target still
  // waiting to be taken.
  logic [31:0] m_pc = 32'h3000;
  logic        m_holding = 1'b0;
  logic [31:0] m_held = '0;
  logic        m_tgt_v = 1'b0;
  logic [31:0] m_tgt = '0;

  logic        e_req, e_valid;
  logic [31:0] e_pc, e_instr;

  always_comb begin
    e_req = 1'b0; e_valid = 1'b0; e_pc = 32'h3000; e_instr = '0;
    if (reset) begin
      e_pc = m_pc;
      if (m_holding) begin
        e_valid = 1'b1; e_instr = m_held;
      end else begin
        e_req = 1'b1;
        if (imem_ready) begin e_valid = 1'b1; e_instr = imem_rdata; end
      end
    end
  end

  always @(posedge clk) begin
    logic        cons, cap;
    logic [31:0] t;
    cons = e_valid && !F_STALL;
    cap  = redirect_valid && !F_STALL;
    t    = redirect_pc & 32'hFFFF_FFFC;
    if (!reset) begin
      m_pc <= 32'h3000; m_holding <= 1'b0; m_held <= '0; m_tgt_v <= 1'b0; m_tgt <= '0;
    end else if (cons) begin
      m_holding <= 1'b0;
      // targets are taken oldest first; an unused new target stays waiting
      m_pc    <= m_tgt_v ? m_tgt : (cap ? t : m_pc + 32'd4);
      m_tgt_v <= m_tgt_v && cap;
      m_tgt   <= t;
    end else begin
      if (!m_holding && e_valid && F_STALL) begin m_holding <= 1'b1; m_held <= imem_rdata; end
      if (cap) begin m_tgt_v <= 1'b1; m_tgt <= t; end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("model F_PC", F_PC, e_pc);
      check("model F_inStr", F_inStr, e_instr);
      check("model F_valid", {31'd0, F_valid}, {31'd0, e_valid});
      check("model imem_req", {31'd0, imem_req}, {31'd0, e_req});
      check("model imem_addr", imem_addr, e_pc);
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; F_STALL = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    lat = 0; spec_word = 1'b0; stale = 1'b0;
    next(); next();
    reset = 1'b1;
  endtask

  task automatic lit_pc(input string nm, input logic [31:0] pc, input logic v);
    @(negedge clk);
    check({nm, " F_PC"}, F_PC, pc);
    check({nm, " F_valid"}, {31'd0, F_valid}, {31'd0, v});
  endtask

  int unsigned snap;

  initial begin
    reset = 1'b0; F_STALL = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    next();
    run = 1'b1;
    next();
    @(negedge clk);
    check("reset imem_req", {31'd0, imem_req}, 32'd0);
    check("reset F_PC", F_PC, 32'h3000);
    next();

    // sequential, zero-wait
    do_reset();
    lit_pc("seq c1", 32'h3000, 1'b1);
    check("seq c1 F_inStr", F_inStr, 32'h3000);
    next(); lit_pc("seq c2", 32'h3004, 1'b1);
    next(); lit_pc("seq c3", 32'h3008, 1'b1);
    next();

    // latency: two bubbles then the word
    do_reset(); lat = 2;
    lit_pc("lat c1", 32'h3000, 1'b0);
    check("lat c1 F_inStr", F_inStr, 32'h0);
    next(); lit_pc("lat c2", 32'h3000, 1'b0);
    check("lat c2 imem_addr", imem_addr, 32'h3000);
    next(); lit_pc("lat c3", 32'h3000, 1'b1);
    next(); lit_pc("lat c4", 32'h3004, 1'b0);
    check("lat c4 imem_req", {31'd0, imem_req}, 32'd1);
    next();

    // stall hold, redirect under stall ignored
    do_reset(); spec_word = 1'b1;
    lit_pc("hold c1", 32'h3000, 1'b1);
    next(); F_STALL = 1'b1;
    lit_pc("hold c2", 32'h3004, 1'b1);
    check("hold c2 F_inStr", F_inStr, 32'h2408_0001);
    next(); redirect_valid = 1'b1; redirect_pc = 32'h5000;
    lit_pc("hold c3", 32'h3004, 1'b1);
    check("hold c3 imem_req", {31'd0, imem_req}, 32'd0);
    check("hold c3 F_inStr", F_inStr, 32'h2408_0001);
    next(); F_STALL = 1'b0; redirect_valid = 1'b0;
    lit_pc("hold c4", 32'h3004, 1'b1);
    check("hold c4 F_inStr", F_inStr, 32'h2408_0001);
    next(); lit_pc("hold c5", 32'h3008, 1'b1);
    next();

    // branch with ready delay slot
    do_reset(); snap = n300c;
    lit_pc("br c1", 32'h3000, 1'b1);
    next(); lit_pc("br c2", 32'h3004, 1'b1);
    next(); redirect_valid = 1'b1; redirect_pc = 32'h3103;
    lit_pc("br c3", 32'h3008, 1'b1);
    next(); redirect_valid = 1'b0;
    lit_pc("br c4", 32'h3100, 1'b1);
    next(); lit_pc("br c5", 32'h3104, 1'b1);
    check("br 300C never requested", n300c, snap);
    next();

    // branch with slow delay slot, then a pending target vs new redirect
    do_reset();
    lit_pc("slow c1", 32'h3000, 1'b1);
    next(); lit_pc("slow c2", 32'h3004, 1'b1);
    next(); lit_pc("slow c3", 32'h3008, 1'b1);
    next(); lat = 2; redirect_valid = 1'b1; redirect_pc = 32'h3200;
    lit_pc("slow c4", 32'h300C, 1'b0);
    next(); redirect_valid = 1'b0;
    lit_pc("slow c5", 32'h300C, 1'b0);
    next(); redirect_valid = 1'b1; redirect_pc = 32'h3300;
    lit_pc("slow c6", 32'h300C, 1'b1);
    next(); lat = 0; redirect_valid = 1'b0;
    lit_pc("slow c7", 32'h3200, 1'b1);
    next(); lit_pc("slow c8", 32'h3300, 1'b1);
    next(); lit_pc("slow c9", 32'h3304, 1'b1);
    next();

    // reset mid-fetch with a stale ready
    do_reset();
    lit_pc("rst c1", 32'h3000, 1'b1);
    next(); next(); next();
    lit_pc("rst c4", 32'h300C, 1'b1);
    next(); lat = 3;
    lit_pc("rst c5", 32'h3010, 1'b0);
    next(); reset = 1'b0; stale = 1'b1;
    lit_pc("rst c6", 32'h3000, 1'b0);
    check("rst c6 imem_req", {31'd0, imem_req}, 32'd0);
    next(); lit_pc("rst c7", 32'h3000, 1'b0);
    next(); reset = 1'b1; stale = 1'b0; lat = 0;
    lit_pc("rst c8", 32'h3000, 1'b1);
    check("rst c8 imem_addr", imem_addr, 32'h3000);
    next();

    // 32-bit wrap, redirect at same edge as consume, low bits masked
    do_reset(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    lit_pc("wrap c1", 32'h3000, 1'b1);
    next(); redirect_valid = 1'b0;
    lit_pc("wrap c2", 32'hFFFF_FFFC, 1'b1);
    next(); lit_pc("wrap c3", 32'h0000_0000, 1'b1);
    next(); lit_pc("wrap c4", 32'h0000_0004, 1'b1);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
